// File: rtl/timer_bus_arbiter_if.sv
// Bus bundle between the requesters, the round-robin arbiter and the timer register port.
// slave = arbiter view, master = requester/timer (environment) view.
interface timer_bus_arbiter_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]    req;
    logic [NUM_REQ-1:0]    req_we;
    logic [4*NUM_REQ-1:0]  req_addr;
    logic [32*NUM_REQ-1:0] req_wdata;
    logic [NUM_REQ-1:0]    ack;
    logic [31:0]           ack_rdata;
    logic                  ack_err;
    logic                  t_wr_en;
    logic                  t_rd_en;
    logic [3:0]            t_addr;
    logic [31:0]           t_wdata;
    logic [31:0]           t_rdata;
    logic [1:0]            fsm_state;

    // Handshake: req[i] is a level held until ack[i] pulses for one cycle; the
    // transaction is latched at grant, so req may drop afterwards without aborting it.
    modport slave (
        input  req, req_we, req_addr, req_wdata, t_rdata,
        output ack, ack_rdata, ack_err, t_wr_en, t_rd_en, t_addr, t_wdata, fsm_state
    );

    modport master (
        output req, req_we, req_addr, req_wdata, t_rdata,
        input  ack, ack_rdata, ack_err, t_wr_en, t_rd_en, t_addr, t_wdata, fsm_state
    );
endinterface

// File: rtl/timer_bus_arbiter.sv
// Round-robin arbiter sharing one timer register port among NUM_REQ requesters.
// Optional macro TIMER_ARB_WPROT_EN: only requester 0 may write CTRL (4'h0) and COMPARE (4'h8).
module timer_bus_arbiter #(
    parameter int NUM_REQ = 4
) (
    input logic                clk,
    input logic                reset,
    timer_bus_arbiter_if.slave bus
);
    localparam int PTR_W = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t             state, state_next;
    logic [PTR_W-1:0]   ptr, ptr_next;
    logic [PTR_W-1:0]   winner, winner_next;
    logic               err_q, err_next;

    logic               t_wr_en_q, t_wr_en_next;
    logic               t_rd_en_q, t_rd_en_next;
    logic [3:0]         t_addr_q, t_addr_next;
    logic [31:0]        t_wdata_q, t_wdata_next;
    logic [NUM_REQ-1:0] ack_q, ack_next;
    logic [31:0]        ack_rdata_q, ack_rdata_next;
    logic               ack_err_q, ack_err_next;

    logic [PTR_W-1:0]   cand;
    logic [PTR_W-1:0]   pick;
    logic               pick_valid;
    logic               pick_we;
    logic [3:0]         pick_addr;
    logic [31:0]        pick_wdata;
    logic               wprot_hit;

    // Scan ptr+1, ptr+2, ... with wrap; first requester found wins.
    always_comb begin
        cand       = '0;
        pick       = ptr;
        pick_valid = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = PTR_W'((int'(ptr) + k) % NUM_REQ);
            if (!pick_valid && bus.req[cand]) begin
                pick       = cand;
                pick_valid = 1'b1;
            end
        end
    end

    assign pick_we    = bus.req_we[pick];
    assign pick_addr  = 4'(bus.req_addr >> (4 * int'(pick)));
    assign pick_wdata = 32'(bus.req_wdata >> (32 * int'(pick)));

`ifdef TIMER_ARB_WPROT_EN
    assign wprot_hit = pick_we && (pick != '0) && (pick_addr == 4'h0 || pick_addr == 4'h8);
`else
    assign wprot_hit = 1'b0;
`endif

    always_comb begin
        state_next     = state;
        ptr_next       = ptr;
        winner_next    = winner;
        err_next       = err_q;
        t_wr_en_next   = 1'b0;
        t_rd_en_next   = 1'b0;
        t_addr_next    = 4'h0;
        t_wdata_next   = 32'h0;
        ack_next       = '0;
        ack_rdata_next = 32'h0;
        ack_err_next   = 1'b0;
        case (state)
            IDLE: begin
                if (pick_valid) begin
                    state_next   = ACCESS;
                    winner_next  = pick;
                    err_next     = wprot_hit;
                    // A blocked write still occupies the slot so timing matches in both builds.
                    t_wr_en_next = pick_we && !wprot_hit;
                    t_rd_en_next = !pick_we;
                    t_addr_next  = pick_addr;
                    t_wdata_next = pick_wdata;
                end
            end
            ACCESS: begin
                state_next     = RESP;
                ack_next       = NUM_REQ'(1) << winner;
                ack_rdata_next = t_rd_en_q ? bus.t_rdata : 32'h0;
                ack_err_next   = err_q;
            end
            RESP: begin
                state_next = IDLE;
                ptr_next   = winner;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            ptr         <= PTR_W'(NUM_REQ - 1);
            winner      <= '0;
            err_q       <= 1'b0;
            t_wr_en_q   <= 1'b0;
            t_rd_en_q   <= 1'b0;
            t_addr_q    <= 4'h0;
            t_wdata_q   <= 32'h0;
            ack_q       <= '0;
            ack_rdata_q <= 32'h0;
            ack_err_q   <= 1'b0;
        end else begin
            state       <= state_next;
            ptr         <= ptr_next;
            winner      <= winner_next;
            err_q       <= err_next;
            t_wr_en_q   <= t_wr_en_next;
            t_rd_en_q   <= t_rd_en_next;
            t_addr_q    <= t_addr_next;
            t_wdata_q   <= t_wdata_next;
            ack_q       <= ack_next;
            ack_rdata_q <= ack_rdata_next;
            ack_err_q   <= ack_err_next;
        end
    end

    assign bus.t_wr_en   = t_wr_en_q;
    assign bus.t_rd_en   = t_rd_en_q;
    assign bus.t_addr    = t_addr_q;
    assign bus.t_wdata   = t_wdata_q;
    assign bus.ack       = ack_q;
    assign bus.ack_rdata = ack_rdata_q;
    assign bus.ack_err   = ack_err_q;
    assign bus.fsm_state = state;
endmodule

// File: tb/tb_timer_bus_arbiter.sv
// Bench for timer_bus_arbiter: directed scenarios plus random traffic checked against a
// transaction-level model (grant order by pointer scan, fixed 1/2/3-cycle timing, register image).
module tb_timer_bus_arbiter;
    localparam int NUM_REQ = 4;
`ifdef TIMER_ARB_WPROT_EN
    localparam bit WPROT = 1'b1;
`else
    localparam bit WPROT = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    timer_bus_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();
    timer_bus_arbiter #(.NUM_REQ(NUM_REQ)) dut (.clk(clk), .reset(reset), .bus(bus));

    // Timer stand-in: four word registers at 0/4/8/C, everything else reads 0.
    logic [31:0] pmem [4];
    assign bus.t_rdata = (bus.t_rd_en && bus.t_addr[1:0] == 2'b00) ? pmem[bus.t_addr[3:2]] : 32'd0;

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    // Reference model state (cycle numbers count rising edges).
    int          cyc;
    bit          in_reset;
    int          free_at, acc_at, ack_at, ptr_m;
    int          e_win;
    bit          e_we, e_err, pend_wr;
    logic [3:0]  e_addr;
    logic [31:0] e_wdata, e_rdata;
    logic [31:0] mmem [4];

    bit          prev_wr;
    logic [3:0]  prev_addr;
    logic [31:0] prev_wdata;
    logic [NUM_REQ-1:0] drop_mask, just_dropped;

    logic [NUM_REQ-1:0] exp_q[$];
    logic [NUM_REQ-1:0] got_q[$];
    int                 got_cyc[$];
    logic [31:0]        got_rd[$];
    bit                 got_err[$];
    int                 start;

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic bit wprot(int w, bit we, logic [3:0] a);
        return WPROT && we && (w != 0) && (a == 4'h0 || a == 4'h8);
    endfunction

    task automatic set_req(int i, bit we, logic [3:0] a, logic [31:0] d);
        bus.req_we[i]            = we;
        bus.req_addr[4*i +: 4]   = a;
        bus.req_wdata[32*i +: 32] = d;
        bus.req[i]               = 1'b1;
    endtask

    task automatic assert_reset();
        reset     = 1'b1;
        bus.req   = '0;
        in_reset  = 1'b1;
        pend_wr   = 1'b0;
        prev_wr   = 1'b0;
        acc_at    = -10;
        ack_at    = -10;
        ptr_m     = NUM_REQ - 1;
        drop_mask = '0;
    endtask

    task automatic release_reset();
        reset    = 1'b0;
        in_reset = 1'b0;
        free_at  = cyc + 1;
    endtask

    task automatic clear_log();
        got_q.delete();
        got_cyc.delete();
        got_rd.delete();
        got_err.delete();
        start = cyc;
    endtask

    task automatic step();
        logic [NUM_REQ-1:0] rq;
        bit acc, ackc;
        int w;
        @(posedge clk);
        #1;
        cyc++;
        if (prev_wr && prev_addr[1:0] == 2'b00) pmem[prev_addr[3:2]] = prev_wdata;
        prev_wr    = bus.t_wr_en;
        prev_addr  = bus.t_addr;
        prev_wdata = bus.t_wdata;

        rq = bus.req;
        if (!in_reset) begin
            if (pend_wr && cyc == ack_at) begin
                if (e_addr[1:0] == 2'b00) mmem[e_addr[3:2]] = e_wdata;
                pend_wr = 1'b0;
            end
            if (cyc >= free_at && rq != '0) begin
                w = -1;
                for (int k = 1; k <= NUM_REQ; k++) begin
                    int j;
                    j = (ptr_m + k) % NUM_REQ;
                    if (w < 0 && rq[j]) w = j;
                end
                e_win   = w;
                e_we    = bus.req_we[w];
                e_addr  = bus.req_addr[4*w +: 4];
                e_wdata = bus.req_wdata[32*w +: 32];
                e_err   = wprot(w, e_we, e_addr);
                e_rdata = (!e_we && e_addr[1:0] == 2'b00) ? mmem[e_addr[3:2]] : 32'd0;
                pend_wr = e_we && !e_err;
                acc_at  = cyc;
                ack_at  = cyc + 1;
                free_at = cyc + 3;
                ptr_m   = w;
            end
        end

        acc  = (cyc == acc_at);
        ackc = (cyc == ack_at);
        chk("t_wr_en",   bus.t_wr_en,   acc ? (e_we && !e_err) : 1'b0);
        chk("t_rd_en",   bus.t_rd_en,   acc && !e_we);
        chk("t_addr",    bus.t_addr,    acc ? e_addr : 4'h0);
        chk("t_wdata",   bus.t_wdata,   acc ? e_wdata : 32'd0);
        chk("ack",       bus.ack,       ackc ? (64'd1 << e_win) : 64'd0);
        chk("ack_rdata", bus.ack_rdata, ackc ? e_rdata : 32'd0);
        chk("ack_err",   bus.ack_err,   ackc ? e_err : 1'b0);

        // Requester agents release req on the cycle after they sample ack.
        just_dropped = drop_mask;
        for (int i = 0; i < NUM_REQ; i++) if (drop_mask[i]) bus.req[i] = 1'b0;
        drop_mask = bus.ack;
        if (bus.ack != '0) begin
            got_q.push_back(bus.ack);
            got_cyc.push_back(cyc);
            got_rd.push_back(bus.ack_rdata);
            got_err.push_back(bus.ack_err);
        end
    endtask

    task automatic run(int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic check_order(string tag);
        chk({tag, "_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            chk(tag, got_q[i], exp_q[i]);
        exp_q.delete();
    endtask

    initial begin
        bus.req       = '0;
        bus.req_we    = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        for (int i = 0; i < 4; i++) begin
            pmem[i] = 32'd0;
            mmem[i] = 32'd0;
        end
        cyc = 0;
        just_dropped = '0;
        assert_reset();
        run(3);
        release_reset();

        // T1: single read of COMPARE from requester 1.
        clear_log();
        set_req(1, 1'b0, 4'h8, 32'd0);
        run(4);
        exp_q.push_back(4'b0010);
        if (got_cyc.size() > 0) chk("t1_latency", got_cyc[0] - start, 2);
        if (got_rd.size() > 0) chk("t1_rdata", got_rd[0], 32'd0);
        check_order("t1_ack");

        // T2: requester 0 programs COMPARE and CTRL, then reads both back.
        clear_log();
        set_req(0, 1'b1, 4'h8, 32'd10); run(5);
        set_req(0, 1'b1, 4'h0, 32'd1);  run(5);
        set_req(0, 1'b0, 4'h8, 32'd0);  run(5);
        set_req(0, 1'b0, 4'h0, 32'd0);  run(5);
        if (got_rd.size() == 4) begin
            chk("t2_rd_compare", got_rd[2], 32'd10);
            chk("t2_rd_ctrl", got_rd[3], 32'd1);
        end else chk("t2_count", got_rd.size(), 4);

        // T3: all four request together after reset.
        assert_reset(); run(2); release_reset();
        clear_log();
        for (int i = 0; i < NUM_REQ; i++) set_req(i, 1'b0, 4'(4 * i), 32'd0);
        run(14);
        for (int i = 0; i < NUM_REQ; i++) exp_q.push_back(4'(1 << i));
        if (got_cyc.size() == 4) begin
            chk("t3_first", got_cyc[0] - start, 2);
            for (int i = 1; i < 4; i++) chk("t3_spacing", got_cyc[i] - got_cyc[i-1], 3);
        end
        check_order("t3_ack");

        // T4: pointer left at 2, requesters 0 and 3 pending.
        set_req(2, 1'b0, 4'h4, 32'd0); run(5);
        clear_log();
        set_req(0, 1'b0, 4'h0, 32'd0);
        set_req(3, 1'b0, 4'hC, 32'd0);
        run(8);
        exp_q.push_back(4'b1000);
        exp_q.push_back(4'b0001);
        check_order("t4_ack");

        // T5: reset lands during the ACCESS cycle of a write.
        set_req(0, 1'b1, 4'h4, 32'd7);
        step();
        chk("t5_wr_before", bus.t_wr_en, 1'b1);
        assert_reset();
        #1;
        chk("t5_wr_en", bus.t_wr_en, 1'b0);
        chk("t5_ack", bus.ack, 4'b0000);
        chk("t5_addr", bus.t_addr, 4'h0);
        run(2);
        release_reset();
        clear_log();
        set_req(1, 1'b0, 4'h0, 32'd0);
        set_req(0, 1'b0, 4'h0, 32'd0);
        run(8);
        exp_q.push_back(4'b0001);
        exp_q.push_back(4'b0010);
        check_order("t5_ack");

        // T6: COMPARE write from requester 2, then from requester 0.
        clear_log();
        set_req(2, 1'b1, 4'h8, 32'd5);  run(5);
        set_req(1, 1'b0, 4'h8, 32'd0);  run(5);
        set_req(0, 1'b1, 4'h8, 32'd5);  run(5);
        set_req(1, 1'b0, 4'h8, 32'd0);  run(5);
        if (got_rd.size() == 4) begin
            chk("t6_err_req2", got_err[0], WPROT);
            chk("t6_cmp_after_req2", got_rd[1], WPROT ? 32'd10 : 32'd5);
            chk("t6_err_req0", got_err[2], 1'b0);
            chk("t6_cmp_after_req0", got_rd[3], 32'd5);
        end else chk("t6_count", got_rd.size(), 4);

        // Random traffic, including abandoned requests and one reset mid-run.
        for (int it = 0; it < 1500; it++) begin
            if (it == 700) begin
                assert_reset(); run(2); release_reset();
            end
            step();
            for (int i = 0; i < NUM_REQ; i++) begin
                if (bus.req[i]) begin
                    if ($urandom_range(0, 49) == 0) bus.req[i] = 1'b0;
                end else if (!just_dropped[i] && !drop_mask[i] && $urandom_range(0, 2) == 0) begin
                    set_req(i, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom);
                end
            end
        end
        run(4);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
